// File: rtl/mmac_operand_loader.sv
// -----------------------------------------------------------------------------
// mmac_operand_loader
//
// Upstream feeder for the matrix MAC unit. A stream of DATA_WIDTH-bit words is
// unpacked into one M_SIZE x M_SIZE operand matrix A followed by one operand
// matrix B (VAR_WIDTH-bit elements, row-major). Complete A/B pairs are held in
// a two-bank ping-pong buffer so the next pair can load while the MAC is still
// consuming the current one.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. Ready never depends combinationally on the
// other side's valid/ready. Once valid is raised it stays high, with the
// payload stable, until the transfer.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset (clears all state and both banks)
//   flush     - synchronous clear of the partial load and of both bank slots
//               (bank contents are left in place, only the pointers/counts reset)
//   in_valid  - input word valid
//   in_ready  - loader can accept a word (fewer than two complete pairs held)
//   in_data   - input word, lane l = in_data[l*VAR_WIDTH +: VAR_WIDTH]
//   op_valid  - a complete A/B pair is presented on mat_a/mat_b
//   op_ready  - MAC accepts the pair
//   mat_a     - flattened matrix A, element k at [k*VAR_WIDTH +: VAR_WIDTH]
//   mat_b     - flattened matrix B, same layout
//   loading   - a partially loaded pair is in progress
// -----------------------------------------------------------------------------
module mmac_operand_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int VAR_WIDTH  = 8,
  parameter int M_SIZE     = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                op_valid,
  input  logic                                op_ready,
  output logic [M_SIZE*M_SIZE*VAR_WIDTH-1:0]  mat_a,
  output logic [M_SIZE*M_SIZE*VAR_WIDTH-1:0]  mat_b,
  output logic                                loading
);

  localparam int EPW   = DATA_WIDTH / VAR_WIDTH;   // elements per word
  localparam int NELEM = M_SIZE * M_SIZE;          // elements per matrix
  localparam int WPM   = NELEM / EPW;              // words per matrix
  localparam int WPP   = 2 * WPM;                  // words per A/B pair
  localparam int MAT_W = NELEM * VAR_WIDTH;
  localparam int WC_W  = (WPP > 1) ? $clog2(WPP) : 1;

  // A word must hold a whole number of elements and a matrix a whole number
  // of words, otherwise the lane-to-element mapping breaks.
  if ((DATA_WIDTH % VAR_WIDTH) != 0) begin : g_bad_lane
    $error("mmac_operand_loader: DATA_WIDTH must be a multiple of VAR_WIDTH");
  end
  if ((NELEM % EPW) != 0) begin : g_bad_words
    $error("mmac_operand_loader: M_SIZE*M_SIZE must be a multiple of EPW");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WC_W-1:0]  wc_q,        wc_d;         // word index within the pair
  logic             wr_bank_q,   wr_bank_d;    // bank being loaded
  logic             rd_bank_q,   rd_bank_d;    // bank presented to the MAC
  logic [1:0]       full_cnt_q,  full_cnt_d;   // complete pairs held (0..2)
  logic [MAT_W-1:0] bank_a_q [2];
  logic [MAT_W-1:0] bank_a_d [2];
  logic [MAT_W-1:0] bank_b_q [2];
  logic [MAT_W-1:0] bank_b_d [2];

  logic accept;
  logic consume;
  logic last_word;
  logic is_b;
  int   w_idx;

  // ---------------------------------------------------------------------------
  // Output decode (registered state only)
  // ---------------------------------------------------------------------------
  assign in_ready = (full_cnt_q != 2'd2);
  assign op_valid = (full_cnt_q != 2'd0);
  assign loading  = (wc_q != '0);
  assign mat_a    = bank_a_q[rd_bank_q];
  assign mat_b    = bank_b_q[rd_bank_q];

  // Flush wins over both handshakes on the same edge.
  assign accept    = in_valid && in_ready && !flush;
  assign consume   = op_valid && op_ready && !flush;
  assign last_word = accept && (wc_q == WC_W'(WPP - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wc_d       = wc_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_cnt_d = full_cnt_q;
    bank_a_d   = bank_a_q;
    bank_b_d   = bank_b_q;
    is_b       = (int'(wc_q) >= WPM);
    w_idx      = is_b ? (int'(wc_q) - WPM) : int'(wc_q);

    if (flush) begin
      wc_d       = '0;
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      full_cnt_d = 2'd0;
    end else begin
      if (accept) begin
        // Element k = w*EPW + l sits at bit k*VAR_WIDTH, so a whole word lands
        // contiguously at w*DATA_WIDTH inside the flattened matrix.
        if (is_b) begin
          bank_b_d[wr_bank_q][w_idx*DATA_WIDTH +: DATA_WIDTH] = in_data;
        end else begin
          bank_a_d[wr_bank_q][w_idx*DATA_WIDTH +: DATA_WIDTH] = in_data;
        end
        wc_d = last_word ? '0 : (wc_q + WC_W'(1));
      end

      if (last_word) begin
        wr_bank_d = ~wr_bank_q;
      end
      if (consume) begin
        rd_bank_d = ~rd_bank_q;
      end

      // Completion and consumption on the same edge leave the count unchanged.
      unique case ({last_word, consume})
        2'b10:   full_cnt_d = full_cnt_q + 2'd1;
        2'b01:   full_cnt_d = full_cnt_q - 2'd1;
        default: full_cnt_d = full_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc_q        <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_cnt_q  <= 2'd0;
      bank_a_q[0] <= '0;
      bank_a_q[1] <= '0;
      bank_b_q[0] <= '0;
      bank_b_q[1] <= '0;
    end else begin
      wc_q        <= wc_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_cnt_q  <= full_cnt_d;
      bank_a_q[0] <= bank_a_d[0];
      bank_a_q[1] <= bank_a_d[1];
      bank_b_q[0] <= bank_b_d[0];
      bank_b_q[1] <= bank_b_d[1];
    end
  end

endmodule

// File: doc/mmac_operand_loader.md
Name: mmac_operand_loader

Overview:
- Upstream feeder for the matrix MAC unit.
- Accepts a stream of DATA_WIDTH-bit words over a valid/ready handshake.
- Unpacks each stream into one M_SIZE x M_SIZE operand matrix A and one operand matrix B of VAR_WIDTH-bit elements.
- Presents each complete A/B pair to the MAC through a ping-pong (two-bank) buffer, so loading of the next pair overlaps consumption of the current one.

Parameters:
- DATA_WIDTH, 64, input word width (mmac_pkg value).
- VAR_WIDTH, 8, matrix element width (mmac_pkg value).
- M_SIZE, 4, matrix dimension (mmac_pkg value).
- Derived EPW = DATA_WIDTH/VAR_WIDTH (8): elements per word.
- Derived WPM = M_SIZE*M_SIZE/EPW (2): words per matrix. M_SIZE*M_SIZE must be a multiple of EPW; violation is an elaboration error.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous clear of partial load and both banks.
- in_valid, in, 1, input word valid.
- in_ready, out, 1, loader can accept a word.
- in_data, in, DATA_WIDTH, input word.
- op_valid, out, 1, complete A/B pair available.
- op_ready, in, 1, MAC accepts the pair.
- mat_a, out, M_SIZE*M_SIZE*VAR_WIDTH, flattened matrix A.
- mat_b, out, M_SIZE*M_SIZE*VAR_WIDTH, flattened matrix B.
- loading, out, 1, a partially loaded pair is in progress.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset values:
  - in_ready=1, op_valid=0, loading=0.
  - mat_a=0 and mat_b=0: both banks cleared.
  - word counter=0, wr_bank=0, rd_bank=0, full_cnt=0.
- Input handshake:
  - A word transfers on an edge where in_valid && in_ready.
  - in_ready = (full_cnt < 2). It is decoded from registered state only, with no combinational path from op_ready.
- Load sequence:
  - The word counter wc runs 0..2*WPM-1.
  - Words 0..WPM-1 fill A; words WPM..2*WPM-1 fill B, in the bank selected by wr_bank.
- Unpacking:
  - Matrix word index w = wc mod WPM.
  - Byte lane l holds in_data[l*VAR_WIDTH +: VAR_WIDTH].
  - That lane goes to element k = w*EPW + l, where row = k / M_SIZE and col = k mod M_SIZE.
  - Flattened output: element k occupies mat_x[k*VAR_WIDTH +: VAR_WIDTH].
- Completion: on the edge accepting word 2*WPM-1:
  - wc wraps to 0.
  - wr_bank toggles.
  - full_cnt increments.
  - op_valid is high in the very next cycle. Latency from last word accepted to op_valid is 1 edge.
- loading = (wc != 0).
- Output:
  - op_valid = (full_cnt != 0).
  - mat_a/mat_b are driven from bank rd_bank and are stable while op_valid && !op_ready.
  - On op_valid && op_ready: rd_bank toggles and full_cnt decrements.
- Simultaneous completion and consumption on the same edge: full_cnt is unchanged; both bank pointers toggle.
- Full: with full_cnt=2, in_ready=0. in_data is ignored and wc holds.
- Empty: with full_cnt=0, op_valid=0. mat_a/mat_b show the stale rd_bank contents and must not be used.
- Flush:
  - Flush has priority over any handshake on the same edge; nothing is transferred that edge.
  - Clears wc, full_cnt, wr_bank and rd_bank to 0.
  - Bank contents are not cleared.
  - op_valid=0 from the next cycle.
- Reset mid-load: all state returns to reset values immediately (asynchronously); a partial pair is discarded.
- No arithmetic on data: the block is pure bit repacking, with no sign handling.

Test Plan:
- Reset then single pair:
  - Stimulus: send A words 0x0706050403020100 and 0x0F0E0D0C0B0A0908, then B words 0x1716151413121110 and 0x1F1E1D1C1B1A1918, with op_ready=1.
  - Required: op_valid for exactly 1 cycle, 1 edge after the 4th word.
  - Required: mat_a element(0,0)=0x00, (1,3)=0x07, (3,3)=0x0F; mat_b element(0,0)=0x10, (3,3)=0x1F.
- Backpressure:
  - Stimulus: op_ready=0; stream 3 pairs continuously.
  - Required: in_ready drops to 0 after the 8th word; the 9th word is held.
  - Required: pair 1 is shown stably until op_ready=1, then pairs 2 and 3 are delivered in order.
- Simultaneous:
  - Stimulus: one bank full with op_valid high; op_ready=1 on the same edge the next pair's last word is accepted.
  - Required: full_cnt stays 1, op_valid stays high, and the data switches to the new pair.
- Input bubbles:
  - Stimulus: toggle in_valid every other cycle.
  - Required: loading=1 after word 1 and 0 after word 4; output data is identical to the gap-free case.
- Flush mid-load:
  - Stimulus: after 2 words, assert flush for 1 cycle, then send a full 4-word pair.
  - Required: only the new pair appears; no mixed elements from the pre-flush words.
- Async reset mid-stream:
  - Stimulus: drop rst_n between edges while full_cnt=1.
  - Required: op_valid=0 and in_ready=1 immediately; the next pair loads from word 0.
